// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester round-robin mux arbiter.
//   ST_IDLE / ST_GNT0 / ST_GNT1 : arbiter FSM state encoding
//   SEL_0 / SEL_1               : mux select values (0 = data_in_0, 1 = data_in_1)
package mux_arb_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_GNT0 = 2'd1;
  localparam logic [STATE_W-1:0] ST_GNT1 = 2'd2;

  localparam logic SEL_0 = 1'b0;
  localparam logic SEL_1 = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/mux2.sv
// One-bit 2:1 multiplexer.
//   d0  : input selected when s = 0
//   d1  : input selected when s = 1
//   s   : select
//   y_c : combinational output
module mux2 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y_c
);

  assign y_c = s ? d1 : d0;

endmodule : mux2

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing a bank of mux2 cells between two requesters.
// Grants one requester at a time, drives the registered mux select, and
// registers the selected data together with a valid flag.
// Optional feature macro: MUX_ARB_TIMEOUT_EN -- forces a grant switch after
// MAX_HOLD consecutive cycles while the other requester is waiting.
// Ports:
//   clk, rst              : clock (rising edge), synchronous active-high reset
//   req_0, req_1          : level requests, held while the datapath is in use
//   data_in_0, data_in_1  : requester data, DATA_W bits each
//   gnt_0, gnt_1          : registered one-hot-or-zero grants
//   sel                   : registered mux select (0 = data_in_0, 1 = data_in_1)
//   data_out              : registered mux output, holds while ungranted
//   data_valid            : data_out carries data from a granted cycle
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              sel,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  // Elaboration guard on the hold limit.
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("mux_arbiter: MAX_HOLD must be >= 1");
  end

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               last;
  logic               last_nxt;
  logic               gnt_0_nxt;
  logic               gnt_1_nxt;
  logic               sel_nxt;
  logic [DATA_W-1:0]  data_out_nxt;
  logic               data_valid_nxt;
  logic [DATA_W-1:0]  mux_out_c;
  logic               hold_expired_c;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;

  // Holder has used its full slot; only matters when the other side waits.
  assign hold_expired_c = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign hold_expired_c = 1'b0;
`endif

  // Datapath: one mux2 per bit, steered by the registered select.
  for (genvar i = 0; i < DATA_W; i++) begin : g_mux
    mux2 u_mux2 (
      .d0  (data_in_0[i]),
      .d1  (data_in_1[i]),
      .s   (sel),
      .y_c (mux_out_c[i])
    );
  end

  // Next-state, round-robin pointer and output decode.
  always_comb begin
    state_nxt      = state;
    last_nxt       = last;
    gnt_0_nxt      = 1'b0;
    gnt_1_nxt      = 1'b0;
    sel_nxt        = sel;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_0 && req_1) begin
          // Tie goes to whoever was not granted last.
          state_nxt = last ? ST_GNT0 : ST_GNT1;
        end else if (req_0) begin
          state_nxt = ST_GNT0;
        end else if (req_1) begin
          state_nxt = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!req_0 || (req_1 && hold_expired_c)) begin
          state_nxt = req_1 ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!req_1 || (req_0 && hold_expired_c)) begin
          state_nxt = req_0 ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Grant/select follow the next state so they are valid right after the edge;
    // select is left untouched in IDLE.
    if (state_nxt == ST_GNT0) begin
      gnt_0_nxt = 1'b1;
      sel_nxt   = SEL_0;
      last_nxt  = 1'b0;
    end else if (state_nxt == ST_GNT1) begin
      gnt_1_nxt = 1'b1;
      sel_nxt   = SEL_1;
      last_nxt  = 1'b1;
    end

    // Data captures through the current select only while a grant is active.
    if (gnt_0 || gnt_1) begin
      data_out_nxt   = mux_out_c;
      data_valid_nxt = 1'b1;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Hold counter: clears on any state change, saturates while a grant is kept.
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    if (state_nxt != state) begin
      hold_cnt_nxt = '0;
    end else if ((state != ST_IDLE) && !hold_expired_c) begin
      hold_cnt_nxt = hold_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last       <= 1'b1;
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      sel        <= SEL_0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      gnt_0      <= gnt_0_nxt;
      gnt_1      <= gnt_1_nxt;
      sel        <= sel_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
    end
  end

endmodule : mux_arbiter
